// File: rtl/ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_bus_arbiter
// Brief  : Shares one single-port RAM among NREQ requesters (req/ack, locked
//          bursts). Define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Rev    : 1.0
// ============================================================================
module ram_bus_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_read,
  output logic              ram_write,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   start;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   pick;
  logic            found;
  logic            in_access;

  // Scan starts one past 'start' and wraps; fixed priority pins start to the top index.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
`ifdef ARB_FIXED_PRIO_EN
    start = IW'(NREQ - 1);
`else
    start = last_q;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(start) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          idx_d       = pick;
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we[idx_q]) begin
          rdata_d = ram_rdata;
        end
        ack_d[idx_q] = 1'b1;
        busy_d       = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (req[idx_q] && lock[idx_q] && (int'(hold_cnt_q) < MAX_HOLD - 1)) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          state_d    = S_ACCESS;
        end else begin
          last_d     = idx_q;
          hold_cnt_d = '0;
          gnt_d      = '0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  // RAM side is decoded from the registered state so the requester's bus is sampled only in ACCESS.
  assign in_access = (state_q == S_ACCESS);

  always_comb begin
    ram_ena   = in_access;
    ram_write = in_access & we[idx_q];
    ram_read  = in_access & ~we[idx_q];
    ram_addr  = '0;
    ram_wdata = '0;
    if (in_access) begin
      ram_addr = addr_in[idx_q*AW +: AW];
      if (we[idx_q]) begin
        ram_wdata = wdata_in[idx_q*DW +: DW];
      end
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_bus_arbiter
// Brief  : Directed scoreboard bench for ram_bus_arbiter (NREQ=3, 8-bit RAM).
// Rev    : 1.0
// ============================================================================
module tb_ram_bus_arbiter;

  typedef struct {
    bit         we;
    bit         lock;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xfer_t;

  typedef struct {
    int         who;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req, lock, we;
  logic [23:0] addr_in, wdata_in;
  logic [2:0]  gnt, ack;
  logic [7:0]  rdata;
  logic        busy, ram_ena, ram_read, ram_write;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic        mem_clr;
  logic [7:0]  mem [256];

  xfer_t pend [3][$];
  exp_t  exp_q [$];
  exp_t  me;
  int    ack_t [$];
  int    cyc;
  int    n_vec;
  int    n_err;

  ram_bus_arbiter #(.NREQ(3), .AW(8), .DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .ack(ack),
    .rdata(rdata), .busy(busy), .ram_ena(ram_ena), .ram_read(ram_read),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h3C] <= 8'hA5;
    end else if (ram_write) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Monitor: pops the scoreboard on every ack and checks bus invariants each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (!$onehot0(gnt) || ((ack & ~gnt) != 3'b000) || (ram_read && ram_write)) begin
        n_err++;
        $display("FAIL invariant: gnt=%b ack=%b rd=%b wr=%b", gnt, ack, ram_read, ram_write);
      end
      if (ack != 3'b000) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ack: got ack=%b, want none", ack);
        end else begin
          me = exp_q.pop_front();
          if (ack != (3'b001 << me.who)) begin
            n_err++;
            $display("FAIL ack_owner: got ack=%b, want requester %0d", ack, me.who);
          end else if (me.rd && rdata !== me.data) begin
            n_err++;
            $display("FAIL ack_rdata: got %h, want %h (requester %0d)", rdata, me.data, me.who);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (pend[i].size() > 0) begin
        req[i]               = 1'b1;
        lock[i]              = pend[i][0].lock;
        we[i]                = pend[i][0].we;
        addr_in[i*8 +: 8]    = pend[i][0].addr;
        wdata_in[i*8 +: 8]   = pend[i][0].wdata;
      end else begin
        req[i]               = 1'b0;
        lock[i]              = 1'b0;
        we[i]                = 1'b0;
        addr_in[i*8 +: 8]    = 8'h00;
        wdata_in[i*8 +: 8]   = 8'h00;
      end
    end
  endtask

  // Requesters advance to their next transfer in the same cycle they see ack.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ack != 3'b000) ack_t.push_back(cyc);
    for (int i = 0; i < 3; i++) begin
      if (ack[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
    drive();
  endtask

  task automatic xfer(int who, bit w, bit l, logic [7:0] a, logic [7:0] d);
    xfer_t x;
    x.we = w; x.lock = l; x.addr = a; x.wdata = d;
    pend[who].push_back(x);
  endtask

  task automatic expect_ack(int who, bit rd, logic [7:0] data);
    exp_t e;
    e.who = who; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    n_vec++;
    if (exp_q.size() > 0 || busy) begin
      n_err++;
      $display("FAIL %s_timeout: %0d acks outstanding busy=%b, want 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic chk_gaps(string name, int want_n, int g0, int g1, int g2, int g3, int g4);
    int g [5];
    g = '{g0, g1, g2, g3, g4};
    chk({name, "_nacks"}, ack_t.size(), want_n);
    for (int k = 1; k < ack_t.size() && k < 6; k++) begin
      chk({name, "_gap"}, ack_t[k] - ack_t[k-1], g[k-1]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; mem_clr = 1'b1;
    drive();
    repeat (3) tick();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_ack", ack, 3'b000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {ram_ena, ram_read, ram_write}, 3'b000);
    chk("rst_addr_wdata", {ram_addr, ram_wdata}, 16'h0000);
    rst = 1'b0; mem_clr = 1'b0;

    // Single read by requester 1
    xfer(1, 1'b0, 1'b0, 8'h3C, 8'h00); expect_ack(1, 1'b1, 8'hA5); drive();
    tick();
    chk("rd_gnt", gnt, 3'b010);
    chk("rd_strobes", {ram_ena, ram_read, ram_write}, 3'b110);
    chk("rd_addr", ram_addr, 8'h3C);
    chk("rd_busy", busy, 1'b1);
    tick();
    chk("rd_ack", ack, 3'b010);
    chk("rd_data", rdata, 8'hA5);
    wait_drain("rd");

    // Write by requester 0, then read back by requester 1
    xfer(0, 1'b1, 1'b0, 8'h10, 8'h5A); expect_ack(0, 1'b0, 8'h00); drive();
    tick();
    chk("wr_gnt", gnt, 3'b001);
    chk("wr_strobes", {ram_ena, ram_read, ram_write}, 3'b101);
    chk("wr_addr_data", {ram_addr, ram_wdata}, 16'h105A);
    tick();
    chk("wr_ack", ack, 3'b001);
    chk("wr_rdata_hold", rdata, 8'hA5);
    wait_drain("wr");
    xfer(1, 1'b0, 1'b0, 8'h10, 8'h00); expect_ack(1, 1'b1, 8'h5A); drive();
    tick();
    chk("rb_strobes", {ram_ena, ram_read, ram_write}, 3'b110);
    chk("rb_wdata_zero", ram_wdata, 8'h00);
    chk("rb_addr", ram_addr, 8'h10);
    wait_drain("rb");
    chk("rb_data", rdata, 8'h5A);

    // Reset while a write is on the RAM bus
    xfer(0, 1'b1, 1'b0, 8'h20, 8'h77); drive();
    tick();
    chk("mid_pre_write", ram_write, 1'b1);
    rst = 1'b1; pend[0].delete(); drive();
    tick();
    chk("mid_strobes", {ram_ena, ram_read, ram_write}, 3'b000);
    chk("mid_gnt_ack", {gnt, ack}, 6'b000000);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rdata", rdata, 8'h00);
    rst = 1'b0;
    tick();
    chk("mid_no_retry", {ack, busy}, 4'b0000);

    // Contention: all three requesting unlocked, two transfers each
    ack_t.delete();
    xfer(0, 1'b0, 1'b0, 8'h3C, 8'h00); xfer(0, 1'b0, 1'b0, 8'h40, 8'h00);
    xfer(1, 1'b0, 1'b0, 8'h10, 8'h00); xfer(1, 1'b1, 1'b0, 8'h41, 8'h22);
    xfer(2, 1'b1, 1'b0, 8'h40, 8'h11); xfer(2, 1'b0, 1'b0, 8'h41, 8'h00);
`ifdef ARB_FIXED_PRIO_EN
    expect_ack(0, 1'b1, 8'hA5); expect_ack(0, 1'b1, 8'h00);
    expect_ack(1, 1'b1, 8'h5A); expect_ack(1, 1'b0, 8'h00);
    expect_ack(2, 1'b0, 8'h00); expect_ack(2, 1'b1, 8'h22);
`else
    expect_ack(0, 1'b1, 8'hA5); expect_ack(1, 1'b1, 8'h5A); expect_ack(2, 1'b0, 8'h00);
    expect_ack(0, 1'b1, 8'h11); expect_ack(1, 1'b0, 8'h00); expect_ack(2, 1'b1, 8'h22);
`endif
    drive();
    wait_drain("cont");
    chk_gaps("cont", 6, 3, 3, 3, 3, 3);

    // Locked burst by requester 2 with requester 0 waiting
    ack_t.delete();
    for (int k = 0; k < 4; k++) xfer(2, 1'b1, 1'b1, 8'h50 + 8'(k), 8'hB0 + 8'(k));
    xfer(2, 1'b0, 1'b1, 8'h52, 8'h00);
    for (int k = 0; k < 4; k++) expect_ack(2, 1'b0, 8'h00);
    expect_ack(0, 1'b1, 8'hB0);
    expect_ack(2, 1'b1, 8'hB2);
    drive();
    tick();
    chk("burst_gnt", gnt, 3'b100);
    xfer(0, 1'b0, 1'b0, 8'h50, 8'h00); drive();
    wait_drain("burst");
    chk_gaps("burst", 6, 2, 2, 2, 3, 3);

    // Requester 0 drops req while its access is on the bus
    xfer(0, 1'b0, 1'b0, 8'h3C, 8'h00); expect_ack(0, 1'b1, 8'hA5); drive();
    tick();
    chk("drop_gnt", gnt, 3'b001);
    pend[0].delete(); req[0] = 1'b0;
    tick();
    chk("drop_ack", ack, 3'b001);
    chk("drop_rdata", rdata, 8'hA5);
    tick();
    chk("drop_idle", {gnt, busy}, 4'b0000);
    tick();
    chk("drop_single_ack", ack, 3'b000);

`ifdef ARB_FIXED_PRIO_EN
    // Requesters 1 and 2 both pending: 1 wins every arbitration until it stops
    for (int k = 0; k < 3; k++) begin
      xfer(1, 1'b0, 1'b0, 8'h3C, 8'h00);
      expect_ack(1, 1'b1, 8'hA5);
    end
    xfer(2, 1'b0, 1'b0, 8'h10, 8'h00); expect_ack(2, 1'b1, 8'h5A);
    drive();
    wait_drain("fixed");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single-port 8-bit data RAM between up to NREQ requesters: the CPU controller, a DMA engine and a debug port.
- Round-robin arbitration with a req/ack handshake and locked bursts bounded by MAX_HOLD.
- Drives the RAM enable, read and write strobes plus the address and write-data mux.
- Sits between the requesters and the RAM instance; the CPU controller becomes requester 0.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 8, address width
DW, 8, data width
MAX_HOLD, 4, max consecutive accesses one requester may keep under lock (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester access request, held until ack
lock  input  NREQ  per-requester burst lock, sampled with req
we  input  NREQ  per-requester write(1)/read(0)
addr_in  input  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
wdata_in  input  NREQ*DW  flattened write data, same packing
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-cycle completion pulse to the granted requester
rdata  output  DW  read data, valid while ack is high
busy  output  1  high in ACCESS and DONE
ram_ena  output  1  RAM enable
ram_read  output  1  RAM read strobe
ram_write  output  1  RAM write strobe
ram_addr  output  AW  muxed address
ram_wdata  output  DW  muxed write data
ram_rdata  input  DW  RAM read data, combinational from ram_addr

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-access): state=IDLE.
  - gnt=0, ack=0, rdata=0, busy=0, all ram_* strobes=0, ram_addr=0, ram_wdata=0.
  - last=NREQ-1, so requester 0 has first priority. hold_cnt=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - gnt=0, strobes low.
  - If any req bit is set, pick the first asserted index scanning last+1, last+2 ... wrapping mod NREQ.
  - Register idx and set gnt=onehot(idx), then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_ena=1; ram_write=we[idx]; ram_read=~we[idx].
  - ram_addr = addr_in[idx]; ram_wdata = wdata_in[idx] (0 on reads).
  - On reads, ram_rdata is captured into rdata at the end of the cycle. Go to DONE.
- DONE (exactly 1 cycle):
  - Strobes low; ack[idx]=1; rdata holds the captured value (unchanged on writes).
  - If req[idx] && lock[idx] && hold_cnt < MAX_HOLD-1: hold_cnt++, gnt kept, go to ACCESS.
  - Else: last=idx, hold_cnt=0, gnt=0, go to IDLE.
- Latency:
  - req rises in cycle N with the arbiter idle: gnt from N+1, RAM strobe in N+1, ack in N+2.
  - Locked burst: one access per 2 cycles.
  - Unlocked back-to-back traffic: one access per 3 cycles (IDLE re-arbitrates).
- Handshake rules:
  - Requester holds req, we, addr_in and wdata_in stable until ack.
  - Values are sampled only in ACCESS.
  - After ack, a requester deasserts req or presents the next transfer in the same cycle.
- Boundary conditions:
  - Requester drops req during ACCESS: the access still completes and ack is still issued.
  - Simultaneous requests: exactly one grant; others wait, with no loss or reordering.
  - Fairness: with all NREQ requesting unlocked, each is served once per NREQ grants.
  - Lock with MAX_HOLD reached: forced release. last=idx, so the next arbitration starts at idx+1.
  - lock without req is ignored.
- Invariants:
  - gnt is always 0 or one-hot; ack is a subset of gnt.
  - ram_read and ram_write are never both high.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: the IDLE winner is the lowest asserted index (requester 0 highest) and last is ignored. Lock and MAX_HOLD still apply.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-ACCESS: assert rst while ram_write=1 -> next cycle all strobes 0, gnt=0, ack=0, state IDLE; the pending write is not retried.
- Single read: RAM[0x3C]=0xA5; req[1]=1, we=0, addr 0x3C at cycle N -> gnt=3'b010 at N+1 with ram_read=1, ram_addr=0x3C; ack[1]=1 and rdata=0xA5 at N+2.
- Contention: req=3'b111 unlocked, held continuously after each ack -> grant order 0,1,2,0,1,2; ack every 3 cycles.
- Locked burst, MAX_HOLD=4: req[2]=lock[2]=1 with req[0]=1 pending -> 4 consecutive acks to requester 2 two cycles apart, then gnt moves to requester 0.
- Write then read-back: requester 0 writes 0x5A to 0x10, then requester 1 reads 0x10 -> rdata=0x5A; ram_wdata=0 during the read cycle.
- Early drop: req[0] deasserted during ACCESS -> ack[0] still pulses once; the arbiter then returns to IDLE.
- With ARB_FIXED_PRIO_EN: req=3'b110 continuously -> requester 1 always wins and requester 2 is starved.
